// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with bursts of up to BURST_LEN beats and occupancy-gated writes. Define ALMOST_FULL_EN to cap writes at AF_LEVEL.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_LEVEL  = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   wr_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_data_in,
  input  logic                   fifo_full,
  input  logic [6:0]             fifo_count,
  output logic                   busy
);

  localparam int unsigned OW = $clog2(NUM_REQ);

`ifdef ALMOST_FULL_EN
  localparam int unsigned LIMIT = AF_LEVEL;
`else
  localparam int unsigned LIMIT = DEPTH;
`endif

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_chk_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..4");
  end
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_chk_burst
    $error("fifo_wr_arbiter: BURST_LEN must be 1..15");
  end
  if (DEPTH > 64 || AF_LEVEL > DEPTH) begin : g_chk_depth
    $error("fifo_wr_arbiter: need AF_LEVEL <= DEPTH <= 64");
  end

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, last_owner, pick;
  logic            pick_vld;
  logic [3:0]      beat_cnt;
  logic [7:0]      byte_in [NUM_REQ];
  logic [7:0]      owner_byte;
  logic [6:0]      occ;
  logic            space, owner_ack, burst_end;
  int unsigned     cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign byte_in[g] = wr_data[8*g +: 8];
  end

  assign owner_byte = byte_in[owner];

  // The in-flight write counts against occupancy, so count 31 plus a pending
  // strobe already closes the window and the FIFO can never overflow.
  assign occ       = fifo_count + {6'd0, fifo_wr_en};
  assign space     = !fifo_full && (occ < 7'(LIMIT));
  assign owner_ack = (state == ST_GRANT) && req[owner] && space;
  assign burst_end = (state == ST_GRANT) &&
                     (!req[owner] || (owner_ack && beat_cnt == 4'(BURST_LEN - 1)));

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(last_owner) + 1 + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_vld && req[OW'(cand)]) begin
        pick     = OW'(cand);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_vld)  state_nxt = ST_GRANT;
      ST_GRANT: if (burst_end) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (owner_ack) ack[owner] = 1'b1;
    busy = (state == ST_GRANT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant        <= '0;
      owner        <= '0;
      last_owner   <= OW'(NUM_REQ - 1);
      beat_cnt     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_wr_en <= owner_ack;
      if (owner_ack) begin
        fifo_data_in <= owner_byte;
        beat_cnt     <= beat_cnt + 4'd1;
      end
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner    <= pick;
            grant    <= NUM_REQ'(1) << pick;
            beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (burst_end) begin
            grant      <= '0;
            last_owner <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus hand sequences for
// almost-full limits, async reset mid-burst and four-way contention.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic [6:0]  fifo_count;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  logic [6:0] occ;
  logic       pend;

`ifdef ALMOST_FULL_EN
  localparam int AF_ACKS1 = 1;
  localparam int AF_ACKS2 = 0;
  localparam int AF_OCC2  = 29;
`else
  localparam int AF_ACKS1 = 4;
  localparam int AF_ACKS2 = 3;
  localparam int AF_OCC2  = 32;
`endif

  fifo_wr_arbiter #(.NUM_REQ(4), .BURST_LEN(4), .DEPTH(32), .AF_LEVEL(28)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wr_data      (wr_data),
    .ack          (ack),
    .grant        (grant),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wd;
    logic [6:0]  cnt;
    logic        full;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        wr_en;
    logic [7:0]  data;
    logic        busy;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic [3:0] r, input logic [31:0] w, input bit mdl,
                      input logic [6:0] c, input logic f);
    @(negedge clk);
    if (mdl) begin
      occ        = occ + {6'd0, pend};
      pend       = fifo_wr_en;
      fifo_count = occ;
    end else begin
      pend       = 1'b0;
      fifo_count = c;
    end
    req       = r;
    wr_data   = w;
    fifo_full = f;
    #1;
  endtask

  initial begin
    int acks, wrs, o;
    logic [3:0] eg;
    logic       ew;

    tbl[0]  = '{4'h1, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{4'h1, 32'h0000_0000, 7'd0,  1'b0, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{4'h1, 32'h0000_0001, 7'd0,  1'b0, 4'h1, 4'h1, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{4'h1, 32'h0000_0002, 7'd0,  1'b0, 4'h1, 4'h1, 1'b1, 8'h01, 1'b1};
    tbl[4]  = '{4'h1, 32'h0000_0003, 7'd0,  1'b0, 4'h1, 4'h1, 1'b1, 8'h02, 1'b1};
    tbl[5]  = '{4'h0, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b1, 8'h03, 1'b0};
    tbl[6]  = '{4'h0, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h03, 1'b0};
    tbl[7]  = '{4'hC, 32'hB0A0_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h03, 1'b0};
    tbl[8]  = '{4'hC, 32'hB0A0_0000, 7'd0,  1'b0, 4'h4, 4'h4, 1'b0, 8'h03, 1'b1};
    tbl[9]  = '{4'hC, 32'hB0A1_0000, 7'd0,  1'b0, 4'h4, 4'h4, 1'b1, 8'hA0, 1'b1};
    tbl[10] = '{4'h8, 32'hB0A1_0000, 7'd0,  1'b0, 4'h0, 4'h4, 1'b1, 8'hA1, 1'b1};
    tbl[11] = '{4'h8, 32'hB0A1_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'hA1, 1'b0};
    tbl[12] = '{4'h8, 32'hB0A1_0000, 7'd0,  1'b0, 4'h8, 4'h8, 1'b0, 8'hA1, 1'b1};
    tbl[13] = '{4'h0, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h8, 1'b1, 8'hB0, 1'b1};
    tbl[14] = '{4'h0, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'hB0, 1'b0};
    tbl[15] = '{4'h1, 32'h0000_00C0, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'hB0, 1'b0};
    tbl[16] = '{4'h1, 32'h0000_00C0, 7'd30, 1'b0, 4'h1, 4'h1, 1'b0, 8'hB0, 1'b1};
    tbl[17] = '{4'h1, 32'h0000_00C1, 7'd31, 1'b0, 4'h0, 4'h1, 1'b1, 8'hC0, 1'b1};
    tbl[18] = '{4'h1, 32'h0000_00C1, 7'd31, 1'b0, 4'h1, 4'h1, 1'b0, 8'hC0, 1'b1};
    tbl[19] = '{4'h1, 32'h0000_00C2, 7'd32, 1'b0, 4'h0, 4'h1, 1'b1, 8'hC1, 1'b1};
    tbl[20] = '{4'h1, 32'h0000_00C2, 7'd32, 1'b0, 4'h0, 4'h1, 1'b0, 8'hC1, 1'b1};
    tbl[21] = '{4'h1, 32'h0000_00C2, 7'd20, 1'b1, 4'h0, 4'h1, 1'b0, 8'hC1, 1'b1};
    tbl[22] = '{4'h1, 32'h0000_00C2, 7'd20, 1'b0, 4'h1, 4'h1, 1'b0, 8'hC1, 1'b1};
    tbl[23] = '{4'h1, 32'h0000_00C3, 7'd20, 1'b0, 4'h1, 4'h1, 1'b1, 8'hC2, 1'b1};
    tbl[24] = '{4'h0, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b1, 8'hC3, 1'b0};
    tbl[25] = '{4'h0, 32'h0000_0000, 7'd0,  1'b0, 4'h0, 4'h0, 1'b0, 8'hC3, 1'b0};

    rst = 1'b0; req = '0; wr_data = '0; fifo_full = 1'b0; fifo_count = '0;
    occ = '0; pend = 1'b0;
    #12;
    chk("reset_state", {ack, grant, fifo_wr_en, fifo_data_in, busy},
        {4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].req, tbl[i].wd, 1'b0, tbl[i].cnt, tbl[i].full);
      chk($sformatf("vec%0d ack/grant/wr_en/data/busy", i),
          {ack, grant, fifo_wr_en, fifo_data_in, busy},
          {tbl[i].ack, tbl[i].grant, tbl[i].wr_en, tbl[i].data, tbl[i].busy});
    end

    // Occupancy limit, starting from 27 entries.
    occ = 7'd27; pend = 1'b0; acks = 0;
    for (int k = 0; k < 6; k++) begin
      step(4'h2, 32'h0000_5500, 1'b1, '0, 1'b0);
      if (ack == 4'h2) acks++;
    end
    chk("af_from27_acks", 64'(acks), 64'(AF_ACKS1));
    step(4'h0, 32'h0, 1'b1, '0, 1'b0);
    step(4'h0, 32'h0, 1'b1, '0, 1'b0);
    chk("af_from27_idle", {63'd0, busy}, 64'd0);

    // Occupancy limit, starting from 29 entries: fills to the cap and stalls.
    occ = 7'd29; pend = 1'b0; acks = 0;
    for (int k = 0; k < 6; k++) begin
      step(4'h2, 32'h0000_5500, 1'b1, '0, 1'b0);
      if (ack == 4'h2) acks++;
    end
    chk("af_from29_acks", 64'(acks), 64'(AF_ACKS2));
    chk("af_stall_hold", {ack, grant, busy}, {4'h0, 4'h2, 1'b1});
    step(4'h0, 32'h0, 1'b1, '0, 1'b0);
    step(4'h0, 32'h0, 1'b1, '0, 1'b0);
    chk("af_from29_occ", 64'(occ), 64'(AF_OCC2));

    // Async reset during beat 2 of a burst from producer 0.
    for (int k = 0; k < 4; k++) step(4'h1, 32'h0000_0077, 1'b0, 7'd0, 1'b0);
    chk("pre_reset_burst", {ack, grant, fifo_wr_en, busy}, {4'h1, 4'h1, 1'b1, 1'b1});
    #1 rst = 1'b0;
    #1;
    chk("async_reset_clear", {ack, grant, fifo_wr_en, fifo_data_in, busy},
        {4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    req = 4'h0;
    @(posedge clk);
    #2 rst = 1'b1;

    // Four-way contention: 4 beats per owner plus one IDLE cycle, order 0..3,0.
    wrs = 0;
    for (int k = 0; k < 22; k++) begin
      step(4'hF, 32'h3322_1100, 1'b0, 7'd0, 1'b0);
      o  = (k / 5) % 4;
      eg = (k % 5 != 0) ? (4'h1 << o) : 4'h0;
      ew = (k > 0) && ((k - 1) % 5 != 0);
      chk($sformatf("contend%0d ack/grant/wr_en", k), {ack, grant, fifo_wr_en}, {eg, eg, ew});
      if (ew) chk($sformatf("contend%0d data", k), 64'(fifo_data_in),
                  64'(8'(17 * (((k - 1) / 5) % 4))));
      if (k >= 1 && k <= 20 && fifo_wr_en) wrs++;
    end
    chk("contend_writes_in_20", 64'(wrs), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for the 32-byte FIFO. It shares the single FIFO write port between NUM_REQ producers and grants bursts of up to BURST_LEN beats. It gates writes on FIFO occupancy so no write is ever issued to a full FIFO. It sits between producer logic and the FIFO's wr_en/data_in/counter/buf_full ports.

Parameters:
NUM_REQ, 4, number of producers (2..4)
BURST_LEN, 4, max beats per grant before forced re-arbitration (1..15)
DEPTH, 32, FIFO depth in bytes; space limit for occupancy check
AF_LEVEL, 28, almost-full threshold (used only with ALMOST_FULL_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-producer write request, level; held while data pending
wr_data  input  8*NUM_REQ  producer data, byte i at [8i+7:8i]
ack  output  NUM_REQ  one-hot, combinational; byte from owner accepted this edge
grant  output  NUM_REQ  one-hot registered current owner; 0 in IDLE
fifo_wr_en  output  1  registered write strobe to FIFO wr_en
fifo_data_in  output  8  registered write data to FIFO data_in
fifo_full  input  1  FIFO buf_full
fifo_count  input  7  FIFO counter (occupancy 0..32)
busy  output  1  high while state is GRANT

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, fifo_wr_en=0, fifo_data_in=8'h00, beat_cnt=0, last_owner=NUM_REQ-1 (requester 0 wins first). ack=0 while in reset.
- space = !fifo_full && (fifo_count + fifo_wr_en) < DEPTH. The 7-bit add includes the in-flight write.
- IDLE:
  - any req high -> GRANT; owner = first requester with req high, searching from last_owner+1 with modulo NUM_REQ wrap.
  - grant registered at that edge; beat_cnt=0.
  - no req -> stay IDLE.
- GRANT:
  - ack[owner] = req[owner] && space. All other ack bits are 0.
  - On an ack edge: fifo_data_in <= wr_data[owner]; fifo_wr_en <= 1; beat_cnt++.
  - No ack: fifo_wr_en <= 0, beat_cnt held.
  - Latency: byte appears on fifo_data_in with fifo_wr_en=1 one cycle after its ack cycle.
- GRANT exits (-> IDLE, grant <= 0, last_owner <= owner) when either:
  - req[owner]=0; or
  - ack occurs with beat_cnt == BURST_LEN-1.
- Re-arbitration always passes through one IDLE cycle. Throughput is therefore BURST_LEN beats per BURST_LEN+1 cycles under contention.
- Full/stall: when space=0, the owner keeps the grant, ack stays 0 and beat_cnt is frozen. The burst resumes when space returns. No beat is lost or duplicated.
- Requester dropping req mid-burst: the grant ends; a partial burst is legal.
- Requesters not granted must hold req and data; they are never acked.
- Max sustained write rate is one byte/cycle. fifo_count 31 with fifo_wr_en=1 yields space=0, so occupancy never exceeds 32.
- Reset asserted mid-burst: all outputs clear immediately. The in-flight fifo_wr_en is dropped; that byte is not written, and its producer must re-send.

Optional Feature:
ALMOST_FULL_EN
- Defined: the space limit is AF_LEVEL instead of DEPTH. That is, space = !fifo_full && (fifo_count + fifo_wr_en) < AF_LEVEL, reserving DEPTH-AF_LEVEL slots for other writers/debug.
- Not defined: the limit is DEPTH. The AF_LEVEL parameter is ignored.

Test Plan:
- Single producer: req[0]=1 with bytes 8'h00..8'h03, FIFO empty -> grant=4'b0001 one cycle after req; ack[0] for 4 consecutive cycles; fifo_wr_en high 4 cycles carrying 00,01,02,03 each one cycle after its ack; then IDLE.
- Contention: req=4'b1111 held continuously, BURST_LEN=4 -> grant order 0,1,2,3,0; each grant 4 beats plus 1 IDLE cycle; 16 bytes in 20 cycles.
- Full stall: fifo_count=31 while a burst is active -> at most one further ack, then ack=0 with grant held. Drop fifo_count to 20 -> ack resumes at the frozen beat_cnt, and the remaining beats complete in order.
- Partial burst: req[2] drops after 2 acks -> grant cleared next edge; the next requester after 2 is chosen; exactly 2 writes from producer 2.
- Async reset mid-burst: rst=0 between clock edges during beat 2 -> grant, fifo_wr_en, busy go 0 without a clock edge. After release, requester 0 is granted first.
- ALMOST_FULL_EN defined, AF_LEVEL=28: fifo_count=27 with no in-flight write -> one ack, then ack=0. Same stimulus without the macro -> acks continue until the count reaches 32.
